// File: rtl/misr_compactor.sv
// Multiple-input signature register used as the LBIST output response analyser.
// Optional MISR_XMASK_EN adds an xmask input that zeroes X-prone response bits.
module misr_compactor #(
    parameter int           N            = 20,
    parameter logic [N-1:0] POLY         = 20'h00008,
    parameter logic [N-1:0] SEED         = '0,
    parameter logic [N-1:0] GOLDEN       = '0,
    parameter int           NUM_PATTERNS = 1024,
    parameter int           CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         en,
`ifdef MISR_XMASK_EN
    input  logic [N-1:0] xmask,
`endif
    input  logic [N-1:0] din,
    output logic [N-1:0] signature,
    output logic         busy,
    output logic         done,
    output logic         pass
);

    typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PATTERNS - 1);

    state_t           state, state_next;
    logic [N-1:0]     sig, sig_next, sig_step, data;
    logic [CNT_W-1:0] count, count_next;
    logic             pass_r, pass_next;
    logic             fb;

`ifdef MISR_XMASK_EN
    assign data = din & ~xmask;
`else
    assign data = din;
`endif

    // Galois-form step: the MSB feeds back into every tapped stage.
    always_comb begin
        fb          = sig[N-1];
        sig_step    = '0;
        sig_step[0] = fb ^ data[0];
        for (int i = 1; i < N; i++)
            sig_step[i] = sig[i-1] ^ data[i] ^ (POLY[i] & fb);
    end

    always_comb begin
        state_next = state;
        sig_next   = sig;
        count_next = count;
        pass_next  = pass_r;
        if (abort) begin
            state_next = IDLE;
            sig_next   = SEED;
            count_next = '0;
            pass_next  = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_next = RUN;
                        sig_next   = SEED;
                        count_next = '0;
                        pass_next  = 1'b0;
                    end
                end
                RUN: begin
                    if (en) begin
                        sig_next   = sig_step;
                        count_next = count + CNT_W'(1);
                        if (count == LAST)
                            state_next = COMPARE;
                    end
                end
                COMPARE: begin
                    pass_next  = (sig == GOLDEN);
                    state_next = DONE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sig    <= SEED;
            count  <= '0;
            pass_r <= 1'b0;
        end else begin
            state  <= state_next;
            sig    <= sig_next;
            count  <= count_next;
            pass_r <= pass_next;
        end
    end

    assign signature = sig;
    assign busy      = (state == RUN) || (state == COMPARE);
    assign done      = (state == DONE);
    assign pass      = pass_r;

endmodule

// File: tb/tb_misr_compactor.sv
// Self-checking bench for misr_compactor: three configurations, table-driven
// sessions plus hand-written stall/abort/reset/restart sequences.
module tb_misr_compactor;

    logic clk, rst_n;

    logic       start_a, abort_a, en_a, busy_a, done_a, pass_a;
    logic [3:0] din_a, sig_a;
`ifdef MISR_XMASK_EN
    logic [3:0] xmask_a;
`endif
    logic       start_b, abort_b, en_b, busy_b, done_b, pass_b;
    logic [3:0] din_b, sig_b;
    logic        start_c, abort_c, en_c, busy_c, done_c, pass_c;
    logic [19:0] din_c, sig_c;

    misr_compactor #(.N(4), .POLY(4'h2), .SEED(4'h0), .GOLDEN(4'h2), .NUM_PATTERNS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .en(en_a),
`ifdef MISR_XMASK_EN
        .xmask(xmask_a),
`endif
        .din(din_a), .signature(sig_a), .busy(busy_a), .done(done_a), .pass(pass_a));

    misr_compactor #(.N(4), .POLY(4'h2), .SEED(4'h8), .GOLDEN(4'h0), .NUM_PATTERNS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .en(en_b),
`ifdef MISR_XMASK_EN
        .xmask(4'h0),
`endif
        .din(din_b), .signature(sig_b), .busy(busy_b), .done(done_b), .pass(pass_b));

    misr_compactor dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .en(en_c),
`ifdef MISR_XMASK_EN
        .xmask(20'h0),
`endif
        .din(din_c), .signature(sig_c), .busy(busy_c), .done(done_c), .pass(pass_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] exp_sig;
        logic       exp_pass;
    } vec_t;

    int passed = 0;
    int total  = 0;
    logic [19:0] sbq[$];
    logic [19:0] msig_a, msig_c;

    function automatic logic [19:0] mstep(logic [19:0] s, logic [19:0] d, logic [19:0] poly, int n);
        logic [19:0] r;
        logic f;
        r = '0;
        f = s[n-1];
        r[0] = f ^ d[0];
        for (int i = 1; i < 20; i++)
            if (i < n) r[i] = s[i-1] ^ d[i] ^ (poly[i] & f);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic start_sess_a();
        @(negedge clk); start_a = 1'b1; en_a = 1'b0;
        @(posedge clk); #1; start_a = 1'b0;
        msig_a = 20'h0;
    endtask

    task automatic word_a(input logic [3:0] d, input logic [3:0] m);
        @(negedge clk); en_a = 1'b1; din_a = d;
`ifdef MISR_XMASK_EN
        xmask_a = m;
`endif
        msig_a = mstep(msig_a, {16'h0, d & ~m}, 20'h2, 4);
        sbq.push_back(msig_a);
        @(posedge clk); #1;
        chk("sig_a_step", {16'h0, sig_a}, sbq.pop_front());
    endtask

    task automatic finish_a(input logic exp_pass);
        @(negedge clk); en_a = 1'b0;
        chk("busy_a_compare", {19'h0, busy_a}, 20'h1);
        chk("done_a_early", {19'h0, done_a}, 20'h0);
        @(posedge clk); #1;
        chk("done_a", {19'h0, done_a}, 20'h1);
        chk("busy_a_done", {19'h0, busy_a}, 20'h0);
        chk("pass_a", {19'h0, pass_a}, {19'h0, exp_pass});
    endtask

    task automatic start_sess_c();
        @(negedge clk); start_c = 1'b1; en_c = 1'b0;
        @(posedge clk); #1; start_c = 1'b0;
        msig_c = 20'h0;
    endtask

    task automatic word_c(input logic [19:0] d);
        @(negedge clk); en_c = 1'b1; din_c = d;
        msig_c = mstep(msig_c, d, 20'h00008, 20);
        sbq.push_back(msig_c);
        @(posedge clk); #1;
        chk("sig_c_step", sig_c, sbq.pop_front());
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4'h1, 4'h0, 4'h2, 1'b1};
        vecs[1] = '{4'h0, 4'h0, 4'h0, 1'b0};
        vecs[2] = '{4'h2, 4'h0, 4'h4, 1'b0};
        vecs[3] = '{4'h0, 4'h2, 4'h2, 1'b1};
        vecs[4] = '{4'h8, 4'h0, 4'h3, 1'b0};
        vecs[5] = '{4'h3, 4'h5, 4'h3, 1'b0};

        rst_n = 1'b0;
        start_a = 0; abort_a = 0; en_a = 0; din_a = 0;
`ifdef MISR_XMASK_EN
        xmask_a = 0;
`endif
        start_b = 0; abort_b = 0; en_b = 0; din_b = 0;
        start_c = 0; abort_c = 0; en_c = 0; din_c = 0;
        msig_a = 0; msig_c = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sig_a", {16'h0, sig_a}, 20'h0);
        chk("rst_sig_b", {16'h0, sig_b}, 20'h8);
        chk("rst_busy_a", {19'h0, busy_a}, 20'h0);
        chk("rst_done_a", {19'h0, done_a}, 20'h0);
        chk("rst_pass_a", {19'h0, pass_a}, 20'h0);
        @(negedge clk); rst_n = 1'b1;

        // Sessions back to back: each one after the first restarts from DONE.
        for (int k = 0; k < 6; k++) begin
            start_sess_a();
            chk("busy_a_run", {19'h0, busy_a}, 20'h1);
            word_a(vecs[k].d0, 4'h0);
            word_a(vecs[k].d1, 4'h0);
            chk("sig_a_table", {16'h0, sig_a}, {16'h0, vecs[k].exp_sig});
            finish_a(vecs[k].exp_pass);
            chk("sig_a_held", {16'h0, sig_a}, {16'h0, vecs[k].exp_sig});
        end

        // Stall tolerance.
        start_sess_a();
        word_a(4'h1, 4'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); en_a = 1'b0; din_a = 4'hF;
            @(posedge clk); #1;
            chk("stall_busy_a", {19'h0, busy_a}, 20'h1);
            chk("stall_done_a", {19'h0, done_a}, 20'h0);
            chk("stall_sig_a", {16'h0, sig_a}, 20'h1);
        end
        word_a(4'h0, 4'h0);
        chk("stall_final_sig", {16'h0, sig_a}, 20'h2);
        finish_a(1'b1);

        // start while busy must not reload the seed or clear the count.
        start_sess_a();
        word_a(4'h1, 4'h0);
        @(negedge clk); en_a = 1'b0; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        chk("run_start_sig", {16'h0, sig_a}, 20'h1);
        chk("run_start_busy", {19'h0, busy_a}, 20'h1);
        word_a(4'h0, 4'h0);
        finish_a(1'b1);

`ifdef MISR_XMASK_EN
        start_sess_a();
        word_a(4'hA, 4'hF);
        word_a(4'h7, 4'hF);
        chk("xmask_full_sig", {16'h0, sig_a}, 20'h0);
        finish_a(1'b0);
        start_sess_a();
        word_a(4'h1, 4'h0);
        word_a(4'h0, 4'h0);
        chk("xmask_none_sig", {16'h0, sig_a}, 20'h2);
        finish_a(1'b1);
`endif

        // Feedback path, single-pattern session.
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        @(negedge clk); en_b = 1'b1; din_b = 4'h0;
        @(posedge clk); #1;
        chk("fb_sig_b", {16'h0, sig_b}, 20'h3);
        @(negedge clk); en_b = 1'b0;
        chk("fb_busy_b", {19'h0, busy_b}, 20'h1);
        @(posedge clk); #1;
        chk("fb_done_b", {19'h0, done_b}, 20'h1);
        chk("fb_pass_b", {19'h0, pass_b}, 20'h0);

        // Abort mid-session on the default configuration; abort beats en.
        start_sess_c();
        for (int k = 0; k < 10; k++) word_c(20'($urandom));
        chk("c_busy_mid", {19'h0, busy_c}, 20'h1);
        @(negedge clk); abort_c = 1'b1; en_c = 1'b1; din_c = 20'hABCDE;
        @(posedge clk); #1; abort_c = 1'b0;
        chk("abort_sig_c", sig_c, 20'h0);
        chk("abort_busy_c", {19'h0, busy_c}, 20'h0);
        chk("abort_done_c", {19'h0, done_c}, 20'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); en_c = 1'b1; din_c = 20'($urandom) | 20'h1;
            @(posedge clk); #1;
            chk("idle_en_sig_c", sig_c, 20'h0);
            chk("idle_en_busy_c", {19'h0, busy_c}, 20'h0);
        end

        // Same again with a one-edge synchronous reset.
        start_sess_c();
        for (int k = 0; k < 10; k++) word_c(20'($urandom));
        @(negedge clk); rst_n = 1'b0; en_c = 1'b1; din_c = 20'h12345;
        @(posedge clk); #1; rst_n = 1'b1;
        chk("rst_mid_sig_c", sig_c, 20'h0);
        chk("rst_mid_busy_c", {19'h0, busy_c}, 20'h0);
        chk("rst_mid_done_c", {19'h0, done_c}, 20'h0);
        @(negedge clk); en_c = 1'b1; din_c = 20'h00001;
        @(posedge clk); #1;
        chk("rst_idle_en_sig_c", sig_c, 20'h0);
        en_c = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
